aec_feeder: RTL
===============

# aec_feeder

Upstream stage of the arithmetic expression calculator (AEC). It accepts ASCII bytes from a host over a valid/ready handshake and filters out illegal or over-length input. Legal bytes are buffered in a FIFO. Once a complete expression (terminated by '=') is buffered, the block replays it to the AEC as a contiguous one-character-per-cycle burst with a first-cycle `ready` strobe. It then holds off the next expression until the AEC asserts `valid`.

## Interface
- `DEPTH`, 32: FIFO depth in bytes; power of two, ≥ `MAX_LEN`+1.
- `MAX_LEN`, 15: maximum non-'=' characters per expression, matching the AEC 16-entry buffer.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: host byte valid.
- `in_data` input 8: host ASCII byte.
- `in_ready` output 1: FIFO can accept a byte.
- `ascii_out` output 8: character to AEC `ascii_in`.
- `aec_ready` output 1: to AEC `ready`; high on the first character cycle only.
- `aec_valid` input 1: AEC `valid`; result produced.
- `busy` output 1: an expression is in flight (SEND or WAIT).
- `err` output 1: sticky error flag.
- `err_clr` input 1: synchronous clear of `err`.

## Operation
- **Legal bytes:** '0'–'9' (48–57), 'a'–'f' (97–102), '(' 40, ')' 41, '*' 42, '+' 43, '-' 45, '=' 61.
- **Input filter** (applied on every handshake, `in_valid && in_ready`):
  - Illegal byte: dropped, `err`←1.
  - Non-'=' byte when `cur_len == MAX_LEN`: dropped, `err`←1.
  - '=' when `cur_len == 0`: dropped, `err`←1. Empty expressions are never forwarded.
  - Otherwise: pushed. `cur_len` increments on a non-'=' push and clears on an '=' push.
- **`eq_cnt`:** counts '=' bytes held in the FIFO. +1 on an '=' push, −1 on an '=' pop, unchanged when both happen in the same cycle. Width is log2(DEPTH)+1.
- **FSM states:**
  - **IDLE:** if `eq_cnt != 0`, pop the head. Register `ascii_out`←head and `aec_ready`←1. Go to SEND. The head is never '=' because of the filter.
  - **SEND:** pop one byte per cycle. Register `ascii_out`←byte, `aec_ready`←0. When the popped byte is '=', go to WAIT. The FIFO cannot underflow in SEND, because the whole expression is already buffered.
  - **WAIT:** `ascii_out`←0, `aec_ready`←0. On `aec_valid`=1, go to IDLE.
- **Pops** occur only in IDLE (when the start condition holds) and in SEND.
- **Pushes** continue in every state. A simultaneous push and pop is allowed, and the count is unchanged.
- **`err` priority:** `err_clr` clears `err`, but a same-cycle error event wins and sets it.
- **`busy`:** 1 in SEND or WAIT.

## Timing
- **Reset values:** `ascii_out`=0, `aec_ready`=0, `busy`=0, `err`=0. Derived outputs follow the reset state: FIFO empty so `in_ready`=1, `eq_cnt`=0, `cur_len`=0, state IDLE.
- **Registered outputs:** `ascii_out`, `aec_ready` and `busy` are all registered. `in_ready` = !full (count < DEPTH), combinational from registers.
- **Latency:** after an '=' push at edge N, `eq_cnt` is nonzero during cycle N+1. The first character and `aec_ready` appear after edge N+1. Characters follow on consecutive cycles, with no gaps. For an expression of L characters, '=' is on `ascii_out` L cycles after the first character.
- **Back-to-back expressions:** `aec_valid` at cycle V moves the FSM to IDLE at V+1. The next expression's first character appears after edge V+1, matching the AEC's RESULT→RESET→BUFFER sequence.
- **`aec_valid` outside WAIT:** ignored.
- **Wrap-around:** FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by the count.
- **Mid-operation reset:** asserting `rst` in any state immediately empties the FIFO, clears `eq_cnt` and `cur_len`, and forces all outputs to their reset values. Any partially sent expression is lost.

## Structure
- **Shared package `aec_pkg`:** ASCII constants (`ASC_LP`, `ASC_RP`, `ASC_MUL`, `ASC_ADD`, `ASC_SUB`, `ASC_EQ`), the state encoding (IDLE, SEND, WAIT), and an `is_legal(byte)` function. The AEC core reuses the constants.
- **Sub-module `aec_char_fifo`** (parameterised by DEPTH, width 8): push, pop, `head`, `count`, `full`, `empty`. The filter, counters and FSM live in `aec_feeder`.

## Test plan
- **Single expression:** push "1+2*3=", then hold `aec_valid`=0. Expect `ascii_out` = 49, 43, 50, 42, 51, 61 on six consecutive cycles, `aec_ready`=1 on the 49 cycle only, then `ascii_out`=0 with `busy`=1 until `aec_valid` is pulsed, then `busy`=0.
- **Queued expressions:** push "a-3=" and "(2+1)=" back-to-back. The second burst must not start until the cycle after the `aec_valid` that follows the first burst. Expect `aec_ready` exactly once per burst.
- **Filtering:** push "1#2=" (35 is illegal). Expect "12=" forwarded and `err`=1. Pulse `err_clr`: `err`=0. Push a lone "=": nothing forwarded, `err`=1.
- **Over-length:** push 17 digits then '='. Expect exactly 15 digits plus '=' forwarded and `err`=1.
- **FIFO full:** with `aec_valid` never asserted, push 40 legal bytes. Expect `in_ready`=0 once 32 are held, no byte lost or duplicated, and correct ordering across pointer wrap after `aec_valid` resumes.
- **Reset mid-SEND:** drop `rst` during the third character of a burst. Expect all outputs 0 immediately and `in_ready`=1. After `rst` is released, the next pushed expression is forwarded cleanly.

Source files
------------

// File: rtl/aec_pkg.sv
// Shared definitions for the arithmetic expression calculator (AEC) front end and core.
// Holds the ASCII character codes, the feeder state encoding and the legal-byte test.
package aec_pkg;

    // Operator and delimiter characters understood by the AEC
    localparam logic [7:0] ASC_LP  = 8'd40;  // '('
    localparam logic [7:0] ASC_RP  = 8'd41;  // ')'
    localparam logic [7:0] ASC_MUL = 8'd42;  // '*'
    localparam logic [7:0] ASC_ADD = 8'd43;  // '+'
    localparam logic [7:0] ASC_SUB = 8'd45;  // '-'
    localparam logic [7:0] ASC_EQ  = 8'd61;  // '='

    // Operand digit ranges: decimal digits and lower-case hex letters
    localparam logic [7:0] ASC_D0  = 8'd48;  // '0'
    localparam logic [7:0] ASC_D9  = 8'd57;  // '9'
    localparam logic [7:0] ASC_HA  = 8'd97;  // 'a'
    localparam logic [7:0] ASC_HF  = 8'd102; // 'f'

    // Feeder sequencing: wait for a whole expression, stream it, wait for the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } aec_state_t;

    // True for every byte the AEC can consume, including the '=' terminator
    function automatic logic is_legal(input logic [7:0] c);
        logic digit;
        logic hex;
        logic op;
        digit = (c >= ASC_D0) && (c <= ASC_D9);
        hex   = (c >= ASC_HA) && (c <= ASC_HF);
        op    = (c == ASC_LP)  || (c == ASC_RP)  || (c == ASC_MUL) ||
                (c == ASC_ADD) || (c == ASC_SUB) || (c == ASC_EQ);
        return digit || hex || op;
    endfunction

endpackage

// File: rtl/aec_char_fifo.sv
// Byte FIFO between the host filter and the AEC replay logic.
// Pointers wrap modulo DEPTH; full and empty are told apart by the occupancy count.
module aec_char_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if a caller misbehaves
    assign do_push = push && (count_q != CNT_MAX);
    assign do_pop  = pop && (count_q != '0);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

endmodule

// File: rtl/aec_feeder.sv
// Upstream stage of the AEC: filters host bytes, buffers them, and replays each complete
// '='-terminated expression as a gap-free burst with a first-character ready strobe.
// The next burst is held off until the AEC reports a result.
module aec_feeder
    import aec_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ascii_out,
    output logic       aec_ready,
    input  logic       aec_valid,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] EQ_ONE  = CW'(1);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    // A whole maximum-length expression plus its '=' must fit in the buffer
    if (DEPTH < MAX_LEN + 1) begin : g_depth_check
        $error("aec_feeder: DEPTH must be at least MAX_LEN+1");
    end

    aec_state_t    state_q, state_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q;
    logic [CW-1:0] eq_cnt_q;
    logic [LW-1:0] cur_len_q;

    logic          hs;
    logic          byte_is_eq;
    logic          err_evt;
    logic          push;
    logic          pop;
    logic          push_eq;
    logic          pop_eq;

    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          head_is_eq;

    aec_char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign hs         = in_valid && in_ready;
    assign byte_is_eq = (in_data == ASC_EQ);
    assign head_is_eq = (fifo_head == ASC_EQ);

    // Reject illegal bytes, over-length expressions and empty expressions
    always_comb begin
        err_evt = 1'b0;
        if (hs) begin
            if (!is_legal(in_data)) begin
                err_evt = 1'b1;
            end else if (!byte_is_eq && (cur_len_q == LEN_MAX)) begin
                err_evt = 1'b1;
            end else if (byte_is_eq && (cur_len_q == '0)) begin
                err_evt = 1'b1;
            end
        end
    end

    assign push    = hs && !err_evt;
    assign push_eq = push && byte_is_eq;
    assign pop_eq  = pop && head_is_eq;

    // Length of the expression currently being accepted from the host
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_len_q <= '0;
        end else if (push) begin
            cur_len_q <= byte_is_eq ? '0 : cur_len_q + LEN_ONE;
        end
    end

    // Number of complete expressions held in the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eq_cnt_q <= '0;
        end else begin
            unique case ({push_eq, pop_eq})
                2'b10:   eq_cnt_q <= eq_cnt_q + EQ_ONE;
                2'b01:   eq_cnt_q <= eq_cnt_q - EQ_ONE;
                default: eq_cnt_q <= eq_cnt_q;
            endcase
        end
    end

    // Sticky error: a new error event outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Replay sequencing: next state, pop request and registered AEC outputs
    always_comb begin
        state_d = state_q;
        ascii_d = ascii_q;
        ready_d = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ascii_d = 8'h00;
                // The head can never be '=' here since empty expressions are dropped
                if ((eq_cnt_q != '0) && (fifo_count != '0)) begin
                    pop     = 1'b1;
                    ascii_d = fifo_head;
                    ready_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // The whole expression is buffered, so the FIFO cannot run dry here
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ascii_d = fifo_head;
                    if (head_is_eq) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                ascii_d = 8'h00;
                if (aec_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                ascii_d = 8'h00;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ascii_q <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ascii_q <= ascii_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ascii_out = ascii_q;
    assign aec_ready = ready_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
